// File: rtl/video_capture_if.sv
// Pixel write bus from the capture sequencer to a frame store.
// There is no backpressure: the store accepts a write every cycle.
interface video_capture_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/video_capture_ctrl.sv
// Frame-grab sequencer: waits for a frame start, walks the active raster at the
// pixel rate and emits one addressed ARGB8888 write per stored pixel.
module video_capture_ctrl #(
    parameter int unsigned H_MAX   = 640,
    parameter int unsigned V_MAX   = 480,
    parameter int unsigned PIX_DIV = 2,
    parameter int unsigned ADDR_W  = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8:0]            rgb_i,
    input  logic                  hblank_i,
    input  logic                  vblank_i,
    input  logic                  arm_i,
    input  logic                  cont_i,
    input  logic                  abort_i,
    video_capture_if.master       wr,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic [9:0]            width_o,
    output logic [9:0]            height_o,
    output logic                  clip_o
);

    localparam int unsigned PH_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [PH_W-1:0] PhLast = PH_W'(PIX_DIV - 1);

    typedef enum logic [1:0] {StIdle, StWait, StActive, StDone} state_e;

    state_e            state_q;
    logic              vb_q, hb_q;
    logic [9:0]        x_q, y_q, max_w_q;
    logic [PH_W-1:0]   phase_q;
    logic [ADDR_W-1:0] row_base_q;

    logic       vb_fall, vb_rise, hb_rise, active, sample, in_range, y_in_range;
    logic [9:0] x_inc, y_inc, max_x;
    logic [31:0] argb;

    assign vb_fall    = vb_q & ~vblank_i;
    assign vb_rise    = ~vb_q & vblank_i;
    assign hb_rise    = ~hb_q & hblank_i;
    assign active     = ~hblank_i & ~vblank_i;
    assign sample     = active && (phase_q == '0);
    assign y_in_range = 32'(y_q) < V_MAX;
    assign in_range   = (32'(x_q) < H_MAX) && y_in_range;

    // Counters saturate so an oversized raster cannot wrap back into range.
    assign x_inc = (x_q == 10'h3FF) ? x_q : x_q + 10'd1;
    assign y_inc = (y_q == 10'h3FF) ? y_q : y_q + 10'd1;
    assign max_x = (x_q > max_w_q) ? x_q : max_w_q;

    assign argb = {8'hFF, rgb_i[2:0], 5'b0, rgb_i[5:3], 5'b0, rgb_i[8:6], 5'b0};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            vb_q         <= 1'b1;
            hb_q         <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
            max_w_q      <= '0;
            phase_q      <= '0;
            row_base_q   <= '0;
            wr.wr_en     <= 1'b0;
            wr.wr_addr   <= '0;
            wr.wr_data   <= '0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            width_o      <= '0;
            height_o     <= '0;
            clip_o       <= 1'b0;
        end else begin
            vb_q         <= vblank_i;
            hb_q         <= hblank_i;
            wr.wr_en     <= 1'b0;
            frame_done_o <= 1'b0;

            if (abort_i) begin
                state_q <= StIdle;
                busy_o  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (arm_i) begin
                            state_q <= StWait;
                            busy_o  <= 1'b1;
                            clip_o  <= 1'b0;
                        end
                    end

                    StWait: begin
                        if (vb_fall) begin
                            state_q    <= StActive;
                            x_q        <= '0;
                            y_q        <= '0;
                            phase_q    <= '0;
                            max_w_q    <= '0;
                            row_base_q <= '0;
                        end
                    end

                    StActive: begin
                        if (!active || phase_q == PhLast) begin
                            phase_q <= '0;
                        end else begin
                            phase_q <= phase_q + 1'b1;
                        end

                        if (sample) begin
                            x_q <= x_inc;
                            if (in_range) begin
                                wr.wr_en   <= 1'b1;
                                wr.wr_addr <= row_base_q + ADDR_W'(x_q);
                                wr.wr_data <= argb;
                            end else begin
                                clip_o <= 1'b1;
                            end
                        end

                        // A line still open when vblank starts counts as a line.
                        if (vb_rise) begin
                            state_q <= StDone;
                            if (x_q != '0) begin
                                y_q     <= y_inc;
                                max_w_q <= max_x;
                            end
                        end else if (hb_rise && x_q != '0) begin
                            y_q     <= y_inc;
                            max_w_q <= max_x;
                            x_q     <= '0;
                            if (y_in_range) begin
                                row_base_q <= row_base_q + ADDR_W'(H_MAX);
                            end
                        end
                    end

                    StDone: begin
                        frame_done_o <= 1'b1;
                        width_o      <= max_w_q;
                        height_o     <= y_q;
                        if (cont_i) begin
                            state_q <= StWait;
                        end else begin
                            state_q <= StIdle;
                            busy_o  <= 1'b0;
                        end
                    end

                    default: begin
                        state_q <= StIdle;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_video_capture_ctrl.sv
// Scoreboard bench: stimulus pushes expected writes/frame results, a negedge monitor pops them.
// Two instances share the raster: a full-size store and a 4x2 store that clips.
module tb_video_capture_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [8:0] rgb;
    logic       hb, vb, arm, cont, abort;

    logic       busy0, done0, clip0, busy1, done1, clip1;
    logic [9:0] w0, h0, w1, h1;

    video_capture_if #(.ADDR_W(19)) wr0 ();
    video_capture_if #(.ADDR_W(19)) wr1 ();

    video_capture_ctrl #(.H_MAX(640), .V_MAX(480), .PIX_DIV(2), .ADDR_W(19)) dut0 (
        .clk(clk), .reset(reset), .rgb_i(rgb), .hblank_i(hb), .vblank_i(vb),
        .arm_i(arm), .cont_i(cont), .abort_i(abort), .wr(wr0.master),
        .busy_o(busy0), .frame_done_o(done0), .width_o(w0), .height_o(h0), .clip_o(clip0)
    );

    video_capture_ctrl #(.H_MAX(4), .V_MAX(2), .PIX_DIV(2), .ADDR_W(19)) dut1 (
        .clk(clk), .reset(reset), .rgb_i(rgb), .hblank_i(hb), .vblank_i(vb),
        .arm_i(arm), .cont_i(cont), .abort_i(abort), .wr(wr1.master),
        .busy_o(busy1), .frame_done_o(done1), .width_o(w1), .height_o(h1), .clip_o(clip1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] q_wr0[$];
    logic [63:0] q_wr1[$];
    logic [19:0] q_dn0[$];
    logic [19:0] q_dn1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk_wr(input int addr, input logic [31:0] d);
        logic [31:0] a;
        a = addr;
        return {13'b0, a[18:0], d};
    endfunction

    function automatic logic [31:0] pack(input logic [8:0] c);
        return {8'hFF, c[2:0], 5'b0, c[5:3], 5'b0, c[8:6], 5'b0};
    endfunction

    // Monitor: every presented write / frame_done must match the head of its queue.
    always @(negedge clk) begin
        if (wr0.wr_en === 1'b1) begin
            if (q_wr0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut0 unexpected write: addr %0d data %h want none", wr0.wr_addr,
                         wr0.wr_data);
            end else check("dut0 write", {13'b0, wr0.wr_addr, wr0.wr_data}, q_wr0.pop_front());
        end
        if (wr1.wr_en === 1'b1) begin
            if (q_wr1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut1 unexpected write: addr %0d data %h want none", wr1.wr_addr,
                         wr1.wr_data);
            end else check("dut1 write", {13'b0, wr1.wr_addr, wr1.wr_data}, q_wr1.pop_front());
        end
        if (done0 === 1'b1) begin
            if (q_dn0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut0 unexpected frame_done: w %0d h %0d want none", w0, h0);
            end else check("dut0 frame geometry", {44'b0, w0, h0}, {44'b0, q_dn0.pop_front()});
        end
        if (done1 === 1'b1) begin
            if (q_dn1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut1 unexpected frame_done: w %0d h %0d want none", w1, h1);
            end else check("dut1 frame geometry", {44'b0, w1, h1}, {44'b0, q_dn1.pop_front()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " wr_en0"}, wr0.wr_en, 0);
        check({tag, " wr_addr0"}, wr0.wr_addr, 0);
        check({tag, " wr_data0"}, wr0.wr_data, 0);
        check({tag, " busy0"}, busy0, 0);
        check({tag, " done0"}, done0, 0);
        check({tag, " width0"}, w0, 0);
        check({tag, " height0"}, h0, 0);
        check({tag, " clip0"}, clip0, 0);
        check({tag, " wr_en1"}, wr1.wr_en, 0);
        check({tag, " busy1"}, busy1, 0);
        check({tag, " clip1"}, clip1, 0);
        check({tag, " width1"}, w1, 0);
    endtask

    // Vertical blank; frame_done is expected two clocks after the first vblank sample.
    task automatic drive_vblank(input int n, input bit exp_done, input bit exp_busy,
                                input int arm_slot);
        for (int i = 0; i < n; i++) begin
            hb  = 1'b1;
            vb  = 1'b1;
            arm = (i == arm_slot);
            step();
            arm = 1'b0;
            if (i < 3) check("frame_done timing", done0, exp_done && (i == 1));
            if (exp_done && i == 1) check("busy at frame_done", busy0, exp_busy);
            if (i == arm_slot) begin
                check("busy after arm", busy0, 1);
                check("clip cleared by arm", clip1, 0);
            end
        end
    endtask

    // Four lines of 6 hblank clocks then 8 pixels x 2 clocks. The first ncap pixels are
    // expected to be written. ev_kind: 1 arm, 2 abort, 3 reset, pulsed at (ev_l, ev_c).
    task automatic drive_lines(input int ncap, input int ev_kind, input int ev_l,
                               input int ev_c, input bit special, input int salt);
        logic [8:0]  px;
        logic [31:0] d;
        int          p;
        bit          fire;
        for (int l = 0; l < 4; l++) begin
            for (int h = 0; h < 6; h++) begin
                hb = 1'b1;
                vb = 1'b0;
                step();
            end
            for (int c = 0; c < 16; c++) begin
                p  = c / 2;
                px = 9'(l * 67 + p * 29 + 5 + salt);
                d  = pack(px);
                if (special && l == 0 && p == 0) begin
                    px = 9'b101_011_110;
                    d  = 32'hFFC0_60A0;
                end
                hb  = 1'b0;
                vb  = 1'b0;
                rgb = px;
                if (c % 2 == 0 && l * 8 + p < ncap) begin
                    q_wr0.push_back(mk_wr(l * 640 + p, d));
                    if (p < 4 && l < 2) q_wr1.push_back(mk_wr(l * 4 + p, d));
                end
                fire = (l == ev_l) && (c == ev_c);
                if (fire) begin
                    if (ev_kind == 1) arm = 1'b1;
                    if (ev_kind == 2) abort = 1'b1;
                    if (ev_kind == 3) reset = 1'b1;
                end
                step();
                if (fire) begin
                    arm   = 1'b0;
                    abort = 1'b0;
                    reset = 1'b0;
                    if (ev_kind == 1) begin
                        check("busy after mid-frame arm", busy0, 1);
                        check("clip cleared by mid-frame arm", clip1, 0);
                    end
                    if (ev_kind == 2) begin
                        check("busy after abort", busy0, 0);
                        check("wr_en after abort", wr0.wr_en, 0);
                    end
                    if (ev_kind == 3) check_zero("reset mid-line");
                end
            end
        end
        if (ncap == 32) begin
            q_dn0.push_back({10'd8, 10'd4});
            q_dn1.push_back({10'd8, 10'd4});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        rgb   = '0;
        hb    = 1'b1;
        vb    = 1'b1;
        arm   = 1'b0;
        cont  = 1'b0;
        abort = 1'b0;
        step();
        step();
        check_zero("reset");
        reset = 1'b0;

        // Single frame armed in vblank, first pixel checks the ARGB packing.
        drive_vblank(10, 0, 0, 3);
        drive_lines(32, 0, -1, -1, 1, 0);
        drive_vblank(10, 1, 0, -1);
        check("clip0 after full frame", clip0, 0);
        check("clip1 after clipped frame", clip1, 1);
        check("width1 unclipped", w1, 8);
        check("height1 unclipped", h1, 4);

        // Arm during an active line: that frame is skipped, the next one captured.
        drive_lines(0, 1, 1, 5, 0, 3);
        drive_vblank(10, 0, 0, -1);
        drive_lines(32, 0, -1, -1, 0, 7);
        drive_vblank(10, 1, 0, -1);

        // Continuous mode for three frames, then dropped.
        cont = 1'b1;
        drive_vblank(10, 0, 0, 3);
        drive_lines(32, 0, -1, -1, 0, 11);
        drive_vblank(10, 1, 1, -1);
        drive_lines(32, 0, -1, -1, 0, 13);
        drive_vblank(10, 1, 1, -1);
        cont = 1'b0;
        drive_lines(32, 0, -1, -1, 0, 17);
        drive_vblank(10, 1, 0, -1);
        drive_lines(0, 0, -1, -1, 0, 19);
        drive_vblank(10, 0, 0, -1);

        // Abort while the 10th write is on the bus.
        drive_vblank(10, 0, 0, 3);
        drive_lines(10, 2, 1, 3, 0, 23);
        drive_vblank(10, 0, 0, -1);
        check("width0 kept over abort", w0, 8);
        check("height0 kept over abort", h0, 4);
        check("busy0 idle after abort", busy0, 0);

        // Reset while the 4th write is on the bus.
        drive_vblank(10, 0, 0, 3);
        drive_lines(4, 3, 0, 7, 0, 29);
        drive_vblank(10, 0, 0, -1);

        step();
        step();
        check("dut0 writes outstanding", q_wr0.size(), 0);
        check("dut1 writes outstanding", q_wr1.size(), 0);
        check("dut0 frames outstanding", q_dn0.size(), 0);
        check("dut1 frames outstanding", q_dn1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/video_capture_ctrl.md
# video_capture_ctrl

Frame-grab sequencer sitting between a game core's video output (9-bit RGB plus hsync/vsync/hblank/vblank) and a pixel store such as the simulation framebuffer or a BRAM frame buffer. On request it waits for the start of a frame, walks the active raster at the pixel rate, and issues one addressed ARGB8888 write per pixel. It signals completion with the measured frame geometry and supports single-shot, continuous and abort operation.

## Interface
Parameters:
- H_MAX, 640, maximum stored width in pixels; x ≥ H_MAX is clipped.
- V_MAX, 480, maximum stored height in lines; y ≥ V_MAX is clipped.
- PIX_DIV, 2, clocks per pixel (core clock / pixel clock); must be ≥ 1.
- ADDR_W, 19, write address width; must satisfy 2^ADDR_W ≥ H_MAX*V_MAX.

Ports:
- clk  in  1  core clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rgb_i  in  9  pixel: [2:0] R, [5:3] G, [8:6] B.
- hblank_i  in  1  horizontal blank, active-high.
- vblank_i  in  1  vertical blank, active-high.
- arm_i  in  1  one-cycle request to capture; honoured only in IDLE.
- cont_i  in  1  continuous mode; sampled in DONE.
- abort_i  in  1  return to IDLE from any state; has priority over all else.
- wr_en_o  out  1  pixel write strobe.
- wr_addr_o  out  ADDR_W  y*H_MAX + x.
- wr_data_o  out  32  {8'hFF, R,5'b0, G,5'b0, B,5'b0}.
- busy_o  out  1  high in WAIT and ACTIVE.
- frame_done_o  out  1  one-cycle pulse at frame end.
- width_o  out  10  widest line seen in last completed frame (pixels, unclipped).
- height_o  out  10  lines seen in last completed frame (unclipped).
- clip_o  out  1  sticky: a pixel fell outside H_MAX×V_MAX since last arm.

## Operation
- States: IDLE, WAIT, ACTIVE, DONE.
- Edge detectors: registers vb_q and hb_q hold the previous vblank_i and hblank_i. vb_fall = vb_q & ~vblank_i; vb_rise = ~vb_q & vblank_i; hb_rise = ~hb_q & hblank_i.
- IDLE: arm_i → WAIT; clear clip_o.
- WAIT: vb_fall → ACTIVE; clear x, y, phase and the running maximum width. Pixels in the vb_fall cycle are not captured.
- ACTIVE:
  - active = ~hblank_i & ~vblank_i.
  - phase resets to 0 when not active; when active it counts modulo PIX_DIV.
  - Sample when active and phase==0, so the first active cycle of every line is sampled.
  - Each sample increments x (10-bit, saturates at 1023).
  - Sample with x<H_MAX and y<V_MAX → write. Otherwise no write and clip_o←1.
  - hb_rise with x>0 → y+1 (saturating at 1023), running max width ← max(max, x), x←0. hb_rise with x==0 leaves y unchanged.
  - vb_rise → DONE. If x>0 at that moment, the partial line counts: y+1 and max update.
- DONE (one cycle): frame_done_o=1; width_o/height_o take the final values. Next state is WAIT if cont_i=1, else IDLE.
- arm_i outside IDLE is ignored.
- abort_i: next state IDLE. A write registered in the abort cycle still appears; no frame_done_o is produced; width_o/height_o are not updated.
- Address arithmetic: y*H_MAX + x, computed with a registered y-row base incremented by H_MAX per line (no multiplier). It is never formed for clipped pixels.

## Timing
- Reset values:
  - State IDLE.
  - wr_en_o=0, wr_addr_o=0, wr_data_o=0.
  - busy_o=0, frame_done_o=0, clip_o=0.
  - width_o=0, height_o=0.
  - vb_q=1, hb_q=1.
  - x, y, phase = 0.
- Write latency: rgb_i is sampled in cycle N; wr_en_o/wr_addr_o/wr_data_o are valid in cycle N+1 for exactly one cycle.
- Spacing: consecutive writes within a line are exactly PIX_DIV cycles apart. With PIX_DIV=1, a write every cycle.
- frame_done_o rises 2 cycles after the clock edge that sampled vblank_i=1: edge detect in ACTIVE, then DONE registered.
- busy_o falls in the same cycle frame_done_o rises.
- Reset mid-frame: all outputs return to reset values next cycle. No further writes.
- The write store is assumed always ready; there is no backpressure.

## Test plan
- Synthetic raster, PIX_DIV=2: 4 lines × 8 pixels, hblank 6 clocks, vblank 10 clocks. Arm during vblank → 32 writes, addresses 0..7, 640..647, 1280..1287, 1920..1927. frame_done_o once; width_o=8, height_o=4; clip_o=0.
- Data packing: rgb_i=9'b101_011_110 → wr_data_o=32'hFFC0_60A0.
- Clipping with H_MAX=4, V_MAX=2 on the same raster → 8 writes only; clip_o=1; width_o=8, height_o=4.
- Arm mid-frame (during an active line) → no writes until the next vb_fall. Then a full frame is captured.
- cont_i=1 over 3 frames → 3 frame_done_o pulses with no gap in capture. Drop cont_i → IDLE after the current frame.
- Abort: abort_i after the 10th write → IDLE next cycle, busy_o=0, no frame_done_o, width/height unchanged. Reset asserted mid-line → all outputs 0 the next cycle.
